// File: rtl/rom_loader_pkg.sv
// Shared Hack platform constants and the loader state encoding.
// The debug/LED block imports this package to decode the loader state.
package rom_loader_pkg;

  localparam int HACK_WORD_W     = 16;
  localparam int HACK_ROM_ADDR_W = 15;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DAT_HI = 3'd2,
    ST_DAT_LO = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } ld_state_t;

  function automatic logic accepts_bytes(input ld_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) || (s == ST_DAT_LO);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte stream from the UART receiver plus the ROM write port of the loader.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = HACK_ROM_ADDR_W
);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [HACK_WORD_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rom_loader.sv
// Boot loader: packs a length-prefixed big-endian byte stream into ROM words
// and holds the Hack CPU in reset until the image is complete.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = HACK_ROM_ADDR_W
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_load_req,
  rom_loader_if.slave    bus,
  output logic           o_cpu_reset,
  output logic           o_done,
  output logic           o_error
);

  localparam int CNT_W = ADDR_W + 1;

  ld_state_t              r_state;
  ld_state_t              w_state_nx;
  logic [7:0]             r_len_hi;
  logic [7:0]             r_word_hi;
  logic [15:0]            r_len;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_inc;
  logic                   r_error;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [HACK_WORD_W-1:0] r_mem_wdata;
  logic                   r_in_ready;
  logic                   r_cpu_reset;
  logic                   r_done;
  logic                   w_accept;
  logic [15:0]            w_len;
  logic                   w_len_zero;
  logic                   w_len_big;
  logic                   w_last_word;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_len       = {r_len_hi, bus.in_data};
  assign w_len_zero  = (w_len == 16'd0);
  // Compared in 32 bits so N == DEPTH is legal and N == DEPTH+1 is not.
  assign w_len_big   = (32'(w_len) > (32'd1 << ADDR_W));
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last_word = (32'(w_count_inc) == 32'(r_len));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_LEN_HI;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_LEN_HI: if (w_accept) w_state_nx = ST_LEN_LO; else w_state_nx = r_state;
      ST_LEN_LO: begin
        if (!w_accept)                    w_state_nx = r_state;
        else if (w_len_zero || w_len_big) w_state_nx = ST_DONE;
        else                              w_state_nx = ST_DAT_HI;
      end
      ST_DAT_HI: if (w_accept) w_state_nx = ST_DAT_LO; else w_state_nx = r_state;
      ST_DAT_LO: if (w_accept) w_state_nx = ST_WRITE;  else w_state_nx = r_state;
      ST_WRITE:  if (w_last_word) w_state_nx = ST_DONE; else w_state_nx = ST_DAT_HI;
      ST_DONE:   if (i_load_req) w_state_nx = ST_LEN_HI; else w_state_nx = r_state;
      default:   w_state_nx = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_len_hi  <= 8'd0;
      r_word_hi <= 8'd0;
      r_len     <= 16'd0;
      r_count   <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_LEN_HI: if (w_accept) r_len_hi <= bus.in_data;
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len   <= w_len;
            r_error <= w_len_big;
          end
        end
        ST_DAT_HI: if (w_accept) r_word_hi <= bus.in_data;
        ST_WRITE:  r_count <= w_count_inc;
        ST_DONE: begin
          if (i_load_req) begin
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_in_ready  <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_mem_we    <= (r_state == ST_DAT_LO) && w_accept;
      if ((r_state == ST_DAT_LO) && w_accept) begin
        r_mem_addr  <= r_count[ADDR_W-1:0];
        r_mem_wdata <= {r_word_hi, bus.in_data};
      end
      r_in_ready  <= accepts_bytes(w_state_nx);
      r_cpu_reset <= (w_state_nx != ST_DONE);
      r_done      <= (w_state_nx == ST_DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_cpu_reset   = r_cpu_reset;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule
